// File: rtl/mips_pkg.sv
// Shared definitions for the data/instruction memory arbiters.
// Holds the FSM state encoding, the port ids and the memory latency limits.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_P = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_W       = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with a fixed-priority or round-robin mode.
// It keeps the last grant so that round-robin alternates on ties.
module rr_arb2
  import mips_pkg::*;
#(
  parameter int PRIO_PIPE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req_p,
  input  logic req_d,
  input  logic update,
  output logic gnt,
  output logic any_req
);

  logic last_grant;

  // NOTE: combinational blocks assign every output first so that no path leaves a latch.
  always_comb begin
    gnt     = PORT_P;
    any_req = req_p | req_d;
    if (PRIO_PIPE != 0) begin
      gnt = req_p ? PORT_P : PORT_D;
    end else if (req_p && req_d) begin
      gnt = ~last_grant;
    end else begin
      gnt = req_p ? PORT_P : PORT_D;
    end
  end

  // Starting from D means P wins the first tie after reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_D;
    end else if (update && any_req) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the pipeline MEM stage (P)
// and the debug/loader port (D), holding the strobes MEM_LAT cycles per access.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter int PRIO_PIPE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [DATA_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_done,
  output logic              p_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt;
  logic              gnt, any_req, gnt_q, we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, p_rdata_q, d_rdata_q;
  logic              grant_now, last_beat;

  assign grant_now = (state_q == IDLE) && any_req;
  assign last_beat = (state_q == ACCESS) && (lat_cnt == '0);

  rr_arb2 #(.PRIO_PIPE(PRIO_PIPE)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_p  (p_req),
    .req_d  (d_req),
    .update (state_q == IDLE),
    .gnt    (gnt),
    .any_req(any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (lat_cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The winner's request is frozen here so later input changes cannot disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt   <= '0;
      gnt_q     <= PORT_P;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (grant_now) begin
      lat_cnt <= LAT_INIT;
      gnt_q   <= gnt;
      we_q    <= (gnt == PORT_P) ? p_we    : d_we;
      addr_q  <= (gnt == PORT_P) ? p_addr  : d_addr;
      wdata_q <= (gnt == PORT_P) ? p_wdata : d_wdata;
    end else if (last_beat) begin
      if (!we_q && gnt_q == PORT_P) p_rdata_q <= mem_rdata;
      if (!we_q && gnt_q == PORT_D) d_rdata_q <= mem_rdata;
    end else if (state_q == ACCESS) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  // Strobes decode from the state alone, so an asynchronous reset drops them at once.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p_done    = 1'b0;
    d_done    = 1'b0;
    unique case (state_q)
      ACCESS: begin
        mem_write = we_q;
        mem_read  = ~we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        p_done = (gnt_q == PORT_P);
        d_done = (gnt_q == PORT_D);
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign p_stall = p_req & ~p_done;
  assign p_rdata = p_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
